dcache_ctrl: RTL and testbench

//   Direct-mapped, write-back, write-allocate data cache between the RISCV_TOP data port
//   and the D-memory SP_SRAM (1-cycle synchronous read).

---
 rtl/dcache_pkg.sv | 37 +++
 rtl/dcache_line_array.sv | 55 +++++
 rtl/dcache_ctrl.sv | 136 +++++++++++++
 tb/tb_dcache_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and address helpers for the direct-mapped data cache.
package dcache_pkg;

  localparam int AWIDTH   = 12;
  localparam int DWIDTH   = 32;
  localparam int IDX_BITS = 3;
  localparam int OFF_BITS = 2;
  localparam int TAG_BITS = AWIDTH - IDX_BITS - OFF_BITS;
  localparam int LINES    = 1 << IDX_BITS;
  localparam int WORDS    = 1 << OFF_BITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WB,
    S_FILL,
    S_RESUME
  } state_t;

  function automatic logic [TAG_BITS-1:0] get_tag(
    input logic [AWIDTH-1:0] a
  );
    return a[AWIDTH-1 -: TAG_BITS];
  endfunction

  function automatic logic [IDX_BITS-1:0] get_idx(
    input logic [AWIDTH-1:0] a
  );
    return a[OFF_BITS +: IDX_BITS];
  endfunction

  function automatic logic [OFF_BITS-1:0] get_off(
    input logic [AWIDTH-1:0] a
  );
    return a[OFF_BITS-1:0];
  endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Tag/valid/dirty/data storage; valid and dirty clear asynchronously.
module dcache_line_array
  import dcache_pkg::*;
(
  input  logic                CLK,
  input  logic                RSTn,
  input  logic [IDX_BITS-1:0] idx,
  input  logic [OFF_BITS-1:0] off,
  output logic [DWIDTH-1:0]   rd_data,
  output logic [TAG_BITS-1:0] rd_tag,
  output logic                rd_valid,
  output logic                rd_dirty,
  input  logic                cpu_we,
  input  logic [DWIDTH-1:0]   cpu_data,
  input  logic                fill_we,
  input  logic [OFF_BITS-1:0] fill_off,
  input  logic [DWIDTH-1:0]   fill_data,
  input  logic                inst_we,
  input  logic [TAG_BITS-1:0] inst_tag
);

  logic [DWIDTH-1:0]   data [LINES][WORDS];
  logic [TAG_BITS-1:0] tags [LINES];
  logic [LINES-1:0]    valid;
  logic [LINES-1:0]    dirty;

  assign rd_data  = data[idx][off];
  assign rd_tag   = tags[idx];
  assign rd_valid = valid[idx];
  assign rd_dirty = dirty[idx];

  always_ff @(posedge CLK) begin
    if (cpu_we)
      data[idx][off] <= cpu_data;
    if (fill_we)
      data[idx][fill_off] <= fill_data;
    if (inst_we)
      tags[idx] <= inst_tag;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      valid <= '0;
      dirty <= '0;
    end else begin
      if (inst_we) begin
        valid[idx] <= 1'b1;
        dirty[idx] <= 1'b0;
      end
      if (cpu_we)
        dirty[idx] <= 1'b1;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Write-back, write-allocate D-cache controller: lookup, miss FSM,
// memory-port muxing and hit/miss counters.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              CACHE_CSN,
  input  logic              CACHE_WEN,
  input  logic [AWIDTH-1:0] CACHE_ADDR,
  input  logic [DWIDTH-1:0] CACHE_DI,
  output logic [DWIDTH-1:0] CACHE_DOUT,
  output logic              CACHE_MISS,
  output logic              D_MEM_CSN,
  output logic              D_MEM_WEN,
  output logic [3:0]        D_MEM_BE,
  output logic [AWIDTH-1:0] D_MEM_ADDR,
  output logic [DWIDTH-1:0] D_MEM_DOUT,
  input  logic [DWIDTH-1:0] D_MEM_DI,
  output logic [31:0]       hitnum,
  output logic [31:0]       missnum
);

  state_t        state;
  logic [2:0]    cnt;
  logic [2:0]    cnt_m1;

  logic [IDX_BITS-1:0] idx;
  logic [OFF_BITS-1:0] off;
  logic [TAG_BITS-1:0] ntag;
  logic [DWIDTH-1:0]   rd_data;
  logic [TAG_BITS-1:0] rd_tag;
  logic                rd_valid;
  logic                rd_dirty;
  logic                hit;
  logic                req;
  logic                cpu_we;
  logic                fill_we;
  logic                inst_we;

  assign idx    = get_idx(CACHE_ADDR);
  assign ntag   = get_tag(CACHE_ADDR);
  assign off    = (state == S_WB) ? cnt[OFF_BITS-1:0]
                                  : get_off(CACHE_ADDR);
  assign cnt_m1 = cnt - 3'd1;
  assign hit    = rd_valid && (rd_tag == ntag);
  assign req    = !CACHE_CSN;

  // The held access of a miss completes in RESUME as a plain hit.
  assign cpu_we  = req && !CACHE_WEN &&
                   ((state == S_IDLE && hit) || state == S_RESUME);
  assign fill_we = (state == S_FILL) && (cnt != 3'd0);
  assign inst_we = (state == S_FILL) && (cnt == 3'd4);

  dcache_line_array u_arr (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .idx       (idx),
    .off       (off),
    .rd_data   (rd_data),
    .rd_tag    (rd_tag),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .cpu_we    (cpu_we),
    .cpu_data  (CACHE_DI),
    .fill_we   (fill_we),
    .fill_off  (cnt_m1[OFF_BITS-1:0]),
    .fill_data (D_MEM_DI),
    .inst_we   (inst_we),
    .inst_tag  (ntag)
  );

  assign CACHE_DOUT = rd_data;
  assign CACHE_MISS = (state == S_WB) || (state == S_FILL) ||
                      (state == S_IDLE && req && !hit);
  assign D_MEM_BE   = 4'b0000;
  assign D_MEM_DOUT = rd_data;

  always_comb begin
    D_MEM_CSN  = 1'b1;
    D_MEM_WEN  = 1'b1;
    D_MEM_ADDR = '0;
    unique case (1'b1)
      state == S_WB: begin
        D_MEM_CSN  = 1'b0;
        D_MEM_WEN  = 1'b0;
        D_MEM_ADDR = {rd_tag, idx, cnt[OFF_BITS-1:0]};
      end
      state == S_FILL: begin
        D_MEM_CSN  = cnt[2];
        D_MEM_ADDR = {ntag, idx, cnt[OFF_BITS-1:0]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state   <= S_IDLE;
      cnt     <= '0;
      hitnum  <= '0;
      missnum <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          cnt <= '0;
          if (req && !hit) begin
            missnum <= missnum + 32'd1;
            state   <= (rd_valid && rd_dirty) ? S_WB : S_FILL;
          end else if (req) begin
            hitnum <= hitnum + 32'd1;
          end
        end
        S_WB: begin
          if (cnt == 3'd3) begin
            cnt   <= '0;
            state <= S_FILL;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        S_FILL: begin
          if (cnt == 3'd4) begin
            cnt   <= '0;
            state <= S_RESUME;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        S_RESUME: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a 1-cycle synchronous SRAM model.
module tb_dcache_ctrl;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        CACHE_CSN;
  logic        CACHE_WEN;
  logic [11:0] CACHE_ADDR;
  logic [31:0] CACHE_DI;
  logic [31:0] CACHE_DOUT;
  logic        CACHE_MISS;
  logic        D_MEM_CSN;
  logic        D_MEM_WEN;
  logic [3:0]  D_MEM_BE;
  logic [11:0] D_MEM_ADDR;
  logic [31:0] D_MEM_DOUT;
  logic [31:0] D_MEM_DI;
  logic [31:0] hitnum;
  logic [31:0] missnum;

  logic [31:0] mem [4096];
  logic [11:0] wlog [$];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  dcache_ctrl dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .CACHE_CSN  (CACHE_CSN),
    .CACHE_WEN  (CACHE_WEN),
    .CACHE_ADDR (CACHE_ADDR),
    .CACHE_DI   (CACHE_DI),
    .CACHE_DOUT (CACHE_DOUT),
    .CACHE_MISS (CACHE_MISS),
    .D_MEM_CSN  (D_MEM_CSN),
    .D_MEM_WEN  (D_MEM_WEN),
    .D_MEM_BE   (D_MEM_BE),
    .D_MEM_ADDR (D_MEM_ADDR),
    .D_MEM_DOUT (D_MEM_DOUT),
    .D_MEM_DI   (D_MEM_DI),
    .hitnum     (hitnum),
    .missnum    (missnum)
  );

  always @(posedge CLK) begin
    if (!D_MEM_CSN) begin
      if (!D_MEM_WEN) begin
        mem[D_MEM_ADDR] <= D_MEM_DOUT;
        wlog.push_back(D_MEM_ADDR);
      end else begin
        D_MEM_DI <= mem[D_MEM_ADDR];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_acc(input logic wen, input logic [11:0] addr,
                        input logic [31:0] di, output int stall,
                        output logic [31:0] dout);
    CACHE_CSN  = 1'b0;
    CACHE_WEN  = wen;
    CACHE_ADDR = addr;
    CACHE_DI   = di;
    stall      = 0;
    @(negedge CLK);
    while (CACHE_MISS && stall < 20) begin
      stall++;
      @(negedge CLK);
    end
    dout = CACHE_DOUT;
    @(posedge CLK);
    #1;
    CACHE_CSN = 1'b1;
    CACHE_WEN = 1'b1;
  endtask

  initial begin
    int st;
    logic [31:0] d;
    for (int i = 0; i < 4096; i++)
      mem[i] = 32'h1000_0000 | i;
    mem[12'h010] = 32'h0000_00A5;
    D_MEM_DI   = '0;
    CACHE_CSN  = 1'b1;
    CACHE_WEN  = 1'b1;
    CACHE_ADDR = '0;
    CACHE_DI   = '0;
    RSTn       = 1'b0;
    #1;
    check("rst_dcsn", {31'd0, D_MEM_CSN}, 32'd1);
    check("rst_dwen", {31'd0, D_MEM_WEN}, 32'd1);
    check("rst_miss", {31'd0, CACHE_MISS}, 32'd0);
    check("rst_hit", hitnum, 32'd0);
    check("rst_miss_n", missnum, 32'd0);
    check("be", {28'd0, D_MEM_BE}, 32'd0);
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
    @(posedge CLK);
    #1;

    // 1: cold read miss
    do_acc(1'b1, 12'h010, '0, st, d);
    check("t1_stall", st, 6);
    check("t1_dout", d, 32'h0000_00A5);
    check("t1_missn", missnum, 32'd1);
    check("t1_hitn", hitnum, 32'd0);

    // 2: neighbouring word hits
    do_acc(1'b1, 12'h011, '0, st, d);
    check("t2_stall", st, 0);
    check("t2_dout", d, 32'h1000_0011);
    check("t2_hitn", hitnum, 32'd1);

    // 3: dirty a word, then evict it
    do_acc(1'b0, 12'h012, 32'h1234, st, d);
    check("t3_wstall", st, 0);
    check("t3_hitn", hitnum, 32'd2);
    check("t3_mem_pre", mem[12'h012], 32'h1000_0012);
    wlog.delete();
    do_acc(1'b1, 12'h092, '0, st, d);
    check("t3_stall", st, 10);
    check("t3_dout", d, 32'h1000_0092);
    check("t3_nwr", wlog.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < wlog.size())
        check("t3_waddr", {20'd0, wlog[i]}, 32'h010 + i);
    check("t3_mem", mem[12'h012], 32'h1234);
    check("t3_mem0", mem[12'h010], 32'h0000_00A5);

    // 4: clean eviction, refill dirty data from memory
    wlog.delete();
    do_acc(1'b1, 12'h012, '0, st, d);
    check("t4_stall", st, 6);
    check("t4_dout", d, 32'h1234);
    check("t4_nwr", wlog.size(), 0);
    check("t4_missn", missnum, 32'd3);

    // 5: write miss allocates, word lands in RESUME
    do_acc(1'b0, 12'h0A0, 32'h55, st, d);
    check("t5_stall", st, 6);
    do_acc(1'b1, 12'h0A0, '0, st, d);
    check("t5_rstall", st, 0);
    check("t5_dout", d, 32'h55);
    check("t5_mem", mem[12'h0A0], 32'h1000_00A0);
    check("t5_hitn", hitnum, 32'd3);
    check("t5_missn", missnum, 32'd4);

    // 6: reset in the middle of a fill
    CACHE_CSN  = 1'b0;
    CACHE_WEN  = 1'b1;
    CACHE_ADDR = 12'h0B0;
    repeat (3) @(posedge CLK);
    #1;
    check("t6_fcsn", {31'd0, D_MEM_CSN}, 32'd0);
    check("t6_faddr", {20'd0, D_MEM_ADDR}, 32'h0B2);
    CACHE_CSN = 1'b1;
    RSTn      = 1'b0;
    #1;
    check("t6_miss", {31'd0, CACHE_MISS}, 32'd0);
    check("t6_dcsn", {31'd0, D_MEM_CSN}, 32'd1);
    check("t6_dwen", {31'd0, D_MEM_WEN}, 32'd1);
    check("t6_missn0", missnum, 32'd0);
    check("t6_hitn0", hitnum, 32'd0);
    @(negedge CLK);
    RSTn = 1'b1;
    @(posedge CLK);
    #1;
    do_acc(1'b1, 12'h0B0, '0, st, d);
    check("t6_stall", st, 6);
    check("t6_dout", d, 32'h1000_00B0);
    check("t6_missn", missnum, 32'd1);
    do_acc(1'b1, 12'h0A0, '0, st, d);
    check("t6_inval", st, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
